// File: rtl/hazard_ctrl_p.sv
// Stall/forward controller for the 5-stage F/D/E/M/W pipeline.
// Tuse/Tnew stalls, ERET drain, MDU busy model and stall counter.
module hazard_ctrl_p #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int TW         = 4,
  parameter int ERET_STALL = 3,
  parameter int MUL_LAT    = 5,
  parameter int DIV_LAT    = 10,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [AW-1:0]    d_a1,
  input  logic [AW-1:0]    d_a2,
  input  logic [TW-1:0]    d_tuse1,
  input  logic [TW-1:0]    d_tuse2,
  input  logic [DW-1:0]    d_rd1,
  input  logic [DW-1:0]    d_rd2,
  input  logic             d_eret,
  input  logic             d_mdu_use,
  input  logic [AW-1:0]    e_a1,
  input  logic [AW-1:0]    e_a2,
  input  logic [TW-1:0]    e_tuse1,
  input  logic [TW-1:0]    e_tuse2,
  input  logic [DW-1:0]    e_rd1,
  input  logic [DW-1:0]    e_rd2,
  input  logic [AW-1:0]    e_a3,
  input  logic [TW-1:0]    e_tnew,
  input  logic             e_we,
  input  logic             e_mdu_start,
  input  logic             e_mdu_div,
  input  logic [AW-1:0]    m_a2,
  input  logic [TW-1:0]    m_tuse2,
  input  logic [DW-1:0]    m_rd2,
  input  logic [AW-1:0]    m_a3,
  input  logic [TW-1:0]    m_tnew,
  input  logic             m_we,
  input  logic [DW-1:0]    m_data,
  input  logic [AW-1:0]    w_a3,
  input  logic             w_we,
  input  logic [DW-1:0]    w_data,
  output logic             stall,
  output logic             mdu_busy,
  output logic [DW-1:0]    fwd_d1,
  output logic [DW-1:0]    fwd_d2,
  output logic [DW-1:0]    fwd_e1,
  output logic [DW-1:0]    fwd_e2,
  output logic [DW-1:0]    fwd_m2,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int EW = $clog2(ERET_STALL + 1);
  localparam int ML = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MW = $clog2(ML + 1);
  localparam logic [EW-1:0] ERET_LD = EW'(ERET_STALL);
  localparam logic [MW-1:0] DIV_LD  = MW'(DIV_LAT - 1);
  localparam logic [MW-1:0] MUL_LD  = MW'(MUL_LAT - 1);

  logic [EW-1:0] eret_cnt;
  logic [MW-1:0] mdu_cnt;
  logic          eret_stall;
  logic          h_d1;
  logic          h_d2;

  // Operand a is not ready in time for its use tuse cycles from now.
  function automatic logic hz(
    input logic [AW-1:0] a,
    input logic [TW-1:0] tu,
    input logic          ewe,
    input logic [AW-1:0] ea3,
    input logic [TW-1:0] etn,
    input logic          mwe,
    input logic [AW-1:0] ma3,
    input logic [TW-1:0] mtn
  );
    logic he;
    logic hm;
    he = ewe && (ea3 == a) && (etn > tu);
    hm = mwe && (ma3 == a) && (mtn > tu);
    return (a != '0) && (he || hm);
  endfunction

  // Youngest ready producer wins; zero register is never forwarded.
  function automatic logic [DW-1:0] fw(
    input logic [AW-1:0] a,
    input logic [DW-1:0] rd,
    input logic          mok,
    input logic [AW-1:0] ma3,
    input logic [DW-1:0] md,
    input logic          wwe,
    input logic [AW-1:0] wa3,
    input logic [DW-1:0] wd
  );
    logic [DW-1:0] r;
    if (a == '0)                   r = '0;
    else if (mok && (ma3 == a))    r = md;
    else if (wwe && (wa3 == a))    r = wd;
    else                           r = rd;
    return r;
  endfunction

  // Global D-stage stall from data, ERET and MDU hazards.
  always_comb begin
    h_d1 = hz(d_a1, d_tuse1, e_we, e_a3, e_tnew,
              m_we, m_a3, m_tnew);
    h_d2 = hz(d_a2, d_tuse2, e_we, e_a3, e_tnew,
              m_we, m_a3, m_tnew);
    eret_stall = d_eret && (eret_cnt != EW'(1));
    mdu_busy   = e_mdu_start || (mdu_cnt != '0);
    stall = h_d1 || h_d2 || eret_stall
         || (d_mdu_use && mdu_busy);
  end

  logic m_ok;
  logic m_nok;

  // Operand muxes; M store data only sees the W producer.
  always_comb begin
    m_ok  = m_we && (m_tnew == '0);
    m_nok = 1'b0;
    fwd_d1 = fw(d_a1, d_rd1, m_ok, m_a3, m_data,
                w_we, w_a3, w_data);
    fwd_d2 = fw(d_a2, d_rd2, m_ok, m_a3, m_data,
                w_we, w_a3, w_data);
    fwd_e1 = fw(e_a1, e_rd1, m_ok, m_a3, m_data,
                w_we, w_a3, w_data);
    fwd_e2 = fw(e_a2, e_rd2, m_ok, m_a3, m_data,
                w_we, w_a3, w_data);
    fwd_m2 = fw(m_a2, m_rd2, m_nok, m_a3, m_data,
                w_we, w_a3, w_data);
  end

  logic unused;
  assign unused = ^{e_tuse1, e_tuse2, m_tuse2};

  // ERET drain counter; flush abandons a pending drain.
  always_ff @(posedge clk) begin
    if (reset || flush)
      eret_cnt <= '0;
    else if (eret_cnt == '0 && d_eret)
      eret_cnt <= ERET_LD;
    else if (eret_cnt != '0)
      eret_cnt <= eret_cnt - EW'(1);
  end

  // MDU occupancy model; a new start restarts the count.
  always_ff @(posedge clk) begin
    if (reset)
      mdu_cnt <= '0;
    else if (e_mdu_start)
      mdu_cnt <= e_mdu_div ? DIV_LD : MUL_LD;
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - MW'(1);
  end

  // Free-running stall cycle counter, wraps.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p.
// Second instance uses a 4-bit stall counter for wrap checks.
module tb_hazard_ctrl_p;

  logic clk = 1'b0;
  logic reset, flush;
  logic [4:0]  d_a1, d_a2, e_a1, e_a2, e_a3;
  logic [4:0]  m_a2, m_a3, w_a3;
  logic [3:0]  d_tuse1, d_tuse2, e_tuse1, e_tuse2;
  logic [3:0]  e_tnew, m_tuse2, m_tnew;
  logic [31:0] d_rd1, d_rd2, e_rd1, e_rd2, m_rd2;
  logic [31:0] m_data, w_data;
  logic d_eret, d_mdu_use, e_we, e_mdu_start;
  logic e_mdu_div, m_we, w_we;
  logic stall, mdu_busy, stall4, busy4;
  logic [31:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2;
  logic [31:0] q_d1, q_d2, q_e1, q_e2, q_m2;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_p dut (
    .clk(clk), .reset(reset), .flush(flush),
    .d_a1(d_a1), .d_a2(d_a2),
    .d_tuse1(d_tuse1), .d_tuse2(d_tuse2),
    .d_rd1(d_rd1), .d_rd2(d_rd2),
    .d_eret(d_eret), .d_mdu_use(d_mdu_use),
    .e_a1(e_a1), .e_a2(e_a2),
    .e_tuse1(e_tuse1), .e_tuse2(e_tuse2),
    .e_rd1(e_rd1), .e_rd2(e_rd2),
    .e_a3(e_a3), .e_tnew(e_tnew), .e_we(e_we),
    .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div),
    .m_a2(m_a2), .m_tuse2(m_tuse2), .m_rd2(m_rd2),
    .m_a3(m_a3), .m_tnew(m_tnew), .m_we(m_we),
    .m_data(m_data),
    .w_a3(w_a3), .w_we(w_we), .w_data(w_data),
    .stall(stall), .mdu_busy(mdu_busy),
    .fwd_d1(fwd_d1), .fwd_d2(fwd_d2),
    .fwd_e1(fwd_e1), .fwd_e2(fwd_e2),
    .fwd_m2(fwd_m2), .stall_cnt(stall_cnt)
  );

  hazard_ctrl_p #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .d_a1(d_a1), .d_a2(d_a2),
    .d_tuse1(d_tuse1), .d_tuse2(d_tuse2),
    .d_rd1(d_rd1), .d_rd2(d_rd2),
    .d_eret(d_eret), .d_mdu_use(d_mdu_use),
    .e_a1(e_a1), .e_a2(e_a2),
    .e_tuse1(e_tuse1), .e_tuse2(e_tuse2),
    .e_rd1(e_rd1), .e_rd2(e_rd2),
    .e_a3(e_a3), .e_tnew(e_tnew), .e_we(e_we),
    .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div),
    .m_a2(m_a2), .m_tuse2(m_tuse2), .m_rd2(m_rd2),
    .m_a3(m_a3), .m_tnew(m_tnew), .m_we(m_we),
    .m_data(m_data),
    .w_a3(w_a3), .w_we(w_we), .w_data(w_data),
    .stall(stall4), .mdu_busy(busy4),
    .fwd_d1(q_d1), .fwd_d2(q_d2),
    .fwd_e1(q_e1), .fwd_e2(q_e2),
    .fwd_m2(q_m2), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; d_eret = 0; d_mdu_use = 0;
    d_a1 = 0; d_a2 = 0; d_tuse1 = 0; d_tuse2 = 0;
    d_rd1 = 32'h1; d_rd2 = 32'h2;
    e_a1 = 0; e_a2 = 0; e_tuse1 = 0; e_tuse2 = 0;
    e_rd1 = 32'h3; e_rd2 = 32'h4;
    e_a3 = 0; e_tnew = 0; e_we = 0;
    e_mdu_start = 0; e_mdu_div = 0;
    m_a2 = 0; m_tuse2 = 0; m_rd2 = 32'h5;
    m_a3 = 0; m_tnew = 0; m_we = 0; m_data = 0;
    w_a3 = 0; w_we = 0; w_data = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    exp_cnt = 0;
  endtask

  // check stall this cycle, then clock it through
  task automatic cyc(input logic es, input string tag);
    #1;
    chk(tag, {63'd0, stall}, {63'd0, es});
    if (es) exp_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1;
    do_reset();
    #1;
    chk("rst_cnt", {32'd0, stall_cnt}, 64'd0);
    chk("rst_cnt4", {60'd0, stall_cnt4}, 64'd0);
    chk("rst_busy", {63'd0, mdu_busy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);

    // E producer, Tnew 2 vs Tuse 1 then 2
    e_we = 1; e_a3 = 5; e_tnew = 2;
    d_a1 = 5; d_tuse1 = 1;
    cyc(1, "haz_e_t1");
    d_tuse1 = 2;
    cyc(0, "haz_e_t2");
    // M producer, Tnew 1 vs Tuse 0
    e_we = 0; d_a1 = 0;
    m_we = 1; m_a3 = 6; m_tnew = 1;
    d_a2 = 6; d_tuse2 = 0;
    cyc(1, "haz_m");
    d_a2 = 0; m_a3 = 0;
    cyc(0, "haz_zero");

    // forwarding
    m_we = 1; m_a3 = 7; m_tnew = 0; m_data = 32'hAA;
    w_we = 1; w_a3 = 7; w_data = 32'hBB;
    e_a1 = 7; e_rd1 = 32'h11;
    d_a1 = 7; d_tuse1 = 3;
    m_a2 = 7; m_rd2 = 32'hCC;
    e_a2 = 9; e_rd2 = 32'h99;
    #1;
    chk("fwd_e1_m", {32'd0, fwd_e1}, 64'hAA);
    chk("fwd_d1_m", {32'd0, fwd_d1}, 64'hAA);
    chk("fwd_m2_w", {32'd0, fwd_m2}, 64'hBB);
    chk("fwd_e2_rd", {32'd0, fwd_e2}, 64'h99);
    m_tnew = 1; d_a1 = 0;
    #1;
    chk("fwd_e1_w", {32'd0, fwd_e1}, 64'hBB);
    m_a3 = 0; m_tnew = 0; d_a2 = 0; d_rd2 = 32'h55;
    #1;
    chk("fwd_d2_z", {32'd0, fwd_d2}, 64'h0);
    w_we = 0;
    #1;
    chk("fwd_e1_rd", {32'd0, fwd_e1}, 64'h11);
    idle();

    // ERET drain: three stall cycles then advance
    d_eret = 1;
    cyc(1, "eret_1");
    cyc(1, "eret_2");
    cyc(1, "eret_3");
    cyc(0, "eret_4");
    d_eret = 0;
    cyc(0, "eret_off");
    // flush in second cycle
    d_eret = 1;
    cyc(1, "eretf_1");
    flush = 1;
    cyc(1, "eretf_2");
    chk("eret_flush_cnt", {62'd0, dut.eret_cnt}, 64'd0);
    flush = 0; d_eret = 0;
    cyc(0, "eretf_off");

    // divide: busy for 10 cycles including start
    e_mdu_start = 1; e_mdu_div = 1; d_mdu_use = 1;
    #1;
    chk("div_busy0", {63'd0, mdu_busy}, 64'd1);
    cyc(1, "div_st0");
    e_mdu_start = 0; e_mdu_div = 0;
    for (int i = 1; i < 10; i++) begin
      chk("div_busy", {63'd0, mdu_busy}, 64'd1);
      cyc(1, "div_st");
    end
    chk("div_idle", {63'd0, mdu_busy}, 64'd0);
    cyc(0, "div_st_end");
    // multiply without use: busy 5, no stall
    d_mdu_use = 0; e_mdu_start = 1;
    cyc(0, "mul_st0");
    e_mdu_start = 0;
    for (int i = 1; i < 5; i++) begin
      chk("mul_busy", {63'd0, mdu_busy}, 64'd1);
      cyc(0, "mul_st");
    end
    chk("mul_idle", {63'd0, mdu_busy}, 64'd0);

    // 17 stalls so far: 4-bit counter has wrapped
    chk("cnt17", {32'd0, stall_cnt}, {32'd0, exp_cnt});
    chk("cnt17_w4", {60'd0, stall_cnt4}, 64'd1);

    // 15 stalls, then wrap of 4-bit counter, then reset
    do_reset();
    e_we = 1; e_a3 = 5; e_tnew = 2;
    d_a1 = 5; d_tuse1 = 1;
    for (int i = 0; i < 15; i++) cyc(1, "run15");
    chk("cnt15", {32'd0, stall_cnt}, 64'd15);
    chk("cnt15_w4", {60'd0, stall_cnt4}, 64'd15);
    cyc(1, "run16");
    chk("cnt16", {32'd0, stall_cnt}, 64'd16);
    chk("cnt16_w4", {60'd0, stall_cnt4}, 64'd0);
    do_reset();
    #1;
    chk("cnt_rst", {32'd0, stall_cnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
